// File: rtl/tdc_therm_decoder.sv
// -----------------------------------------------------------------------------
// tdc_therm_decoder
//
// Purpose:
//   Controls a tapped delay-line time-to-digital converter. On a start request
//   it raises the launch edge into the delay line, samples the tap outputs,
//   passes them through a two-stage synchronizer and decodes the captured
//   thermometer code into a ones-count plus bubble and overflow flags. The
//   result is held under a valid/ready handshake. After the transfer the launch
//   edge is pulled low for RECOVER_CYC cycles so the line can settle before
//   the next measurement.
//
// Parameters:
//   N            number of delay-line taps (4..256)
//   CW           width of the count output, $clog2(N+1) by default
//   RECOVER_CYC  cycles spent in RECOVER with launch low (1..255)
//
// Ports:
//   clk       in   sole clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   measurement request, only honoured in IDLE
//   launch    out  registered edge driven into the delay-line input
//   dl_in     in   [N-1:0] tap outputs, bit 0 nearest the launch point
//   valid     out  decoded result available
//   ready     in   consumer accepts the result (only meaningful in HOLD)
//   count     out  [CW-1:0] number of ones in the captured code
//   bubble    out  captured code is not a clean thermometer code
//   overflow  out  captured code is all ones
// -----------------------------------------------------------------------------
module tdc_therm_decoder #(
  parameter int unsigned N           = 64,
  parameter int unsigned CW          = $clog2(N + 1),
  parameter int unsigned RECOVER_CYC = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          launch,
  input  logic [N-1:0]  dl_in,
  output logic          valid,
  input  logic          ready,
  output logic [CW-1:0] count,
  output logic          bubble,
  output logic          overflow
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_CAPT    = 3'd2,
    S_DEC     = 3'd3,
    S_HOLD    = 3'd4,
    S_RECOVER = 3'd5
  } state_t;

  // The recovery counter starts one below RECOVER_CYC; the cycle on which it
  // reads zero is the last RECOVER cycle, giving exactly RECOVER_CYC cycles.
  localparam logic [7:0] REC_LOAD = 8'(RECOVER_CYC - 1);

  state_t          r_state;
  state_t          w_state_nxt;

  logic [N-1:0]    r_stage1;
  logic [N-1:0]    r_stage2;
  logic [7:0]      r_rec_cnt;

  logic            r_launch;
  logic            r_valid;
  logic [CW-1:0]   r_count;
  logic            r_bubble;
  logic            r_overflow;

  logic [CW-1:0]   w_pop;
  logic            w_bubble;
  logic            w_seen_zero;
  logic            w_all_ones;
  logic            w_xfer;

  // ---------------------------------------------------------------------------
  // Decode of the synchronized code. A bubble is any 1 found above a 0 when
  // scanning from the launch end; the popcount is taken regardless so that a
  // bubbled code still produces a usable count.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_pop       = '0;
    w_bubble    = 1'b0;
    w_seen_zero = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      w_pop = w_pop + CW'(r_stage2[i]);
      if (r_stage2[i] && w_seen_zero) begin
        w_bubble = 1'b1;
      end
      if (!r_stage2[i]) begin
        w_seen_zero = 1'b1;
      end
    end
  end

  assign w_all_ones = &r_stage2;
  assign w_xfer     = (r_state == S_HOLD) && ready;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (start) w_state_nxt = S_LAUNCH;
      S_LAUNCH:  w_state_nxt = S_CAPT;
      S_CAPT:    w_state_nxt = S_DEC;
      S_DEC:     w_state_nxt = S_HOLD;
      S_HOLD:    if (w_xfer) w_state_nxt = S_RECOVER;
      S_RECOVER: if (r_rec_cnt == '0) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, capture pipeline and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_stage1   <= '0;
      r_stage2   <= '0;
      r_rec_cnt  <= '0;
      r_launch   <= 1'b0;
      r_valid    <= 1'b0;
      r_count    <= '0;
      r_bubble   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_launch <= 1'b1;
          end
        end
        S_LAUNCH: begin
          r_stage1 <= dl_in;
        end
        S_CAPT: begin
          r_stage2 <= r_stage1;
        end
        S_DEC: begin
          r_count    <= w_pop;
          r_bubble   <= w_bubble;
          r_overflow <= w_all_ones;
          r_valid    <= 1'b1;
        end
        S_HOLD: begin
          // Result registers are left untouched so the last result stays
          // visible after the transfer.
          if (w_xfer) begin
            r_valid   <= 1'b0;
            r_launch  <= 1'b0;
            r_rec_cnt <= REC_LOAD;
          end
        end
        S_RECOVER: begin
          if (r_rec_cnt != '0) begin
            r_rec_cnt <= r_rec_cnt - 8'd1;
          end
        end
        default: begin
          r_launch <= 1'b0;
          r_valid  <= 1'b0;
        end
      endcase
    end
  end

  assign launch   = r_launch;
  assign valid    = r_valid;
  assign count    = r_count;
  assign bubble   = r_bubble;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_tdc_therm_decoder.sv
// -----------------------------------------------------------------------------
// tb_tdc_therm_decoder
//
// Directed bench for tdc_therm_decoder (N=64, RECOVER_CYC=4). Inputs are
// driven and outputs sampled 1 time unit after each rising edge. Expected
// values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_tdc_therm_decoder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        launch;
  logic [63:0] dl_in;
  logic        valid;
  logic        ready;
  logic [6:0]  count;
  logic        bubble;
  logic        overflow;

  int n_vec;
  int n_err;

  tdc_therm_decoder #(
    .N           (64),
    .CW          (7),
    .RECOVER_CYC (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .launch   (launch),
    .dl_in    (dl_in),
    .valid    (valid),
    .ready    (ready),
    .count    (count),
    .bubble   (bubble),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reset values, start ignored during reset, release mid-cycle.
  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b1;
    ready = 1'b0;
    dl_in = '1;
    repeat (3) tick();
    n_vec++;
    if ({launch, valid, bubble, overflow} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_flags: got launch/valid/bubble/ovf=%b expected 0000",
               {launch, valid, bubble, overflow});
    end
    n_vec++;
    if (count !== 7'd0) begin
      n_err++;
      $display("FAIL reset_count: got %0d expected 0", count);
    end
    start = 1'b0;
    rst_n = 1'b1;
  endtask

  // 16-tap code with ready already high: latency, 1-cycle valid, recovery.
  task automatic test_basic;
    ready = 1'b1;
    start = 1'b1;
    dl_in = 64'h0000_0000_0000_FFFF;
    tick();                                   // E0: first edge after reset
    n_vec++;
    if (launch !== 1'b1 || valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_launch: got launch=%b valid=%b expected 1 0", launch, valid);
    end
    start = 1'b0;
    tick();                                   // E1: dl_in sampled
    dl_in = 64'hFFFF_0000_FFFF_0000;
    tick();                                   // E2
    n_vec++;
    if (valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_early_valid: got %b expected 0", valid);
    end
    tick();                                   // E3
    n_vec++;
    if (valid !== 1'b1 || count !== 7'd16 || bubble !== 1'b0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL basic_result: got valid=%b count=%0d bub=%b ovf=%b expected 1 16 0 0",
               valid, count, bubble, overflow);
    end
    tick();                                   // E4: transfer
    n_vec++;
    if (valid !== 1'b0 || launch !== 1'b0 || count !== 7'd16) begin
      n_err++;
      $display("FAIL basic_xfer: got valid=%b launch=%b count=%0d expected 0 0 16",
               valid, launch, count);
    end
    // Hold start high: it must be ignored for the 4 RECOVER cycles.
    start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_vec++;
      if (launch !== 1'b0) begin
        n_err++;
        $display("FAIL basic_recover_%0d: got launch=%b expected 0", k, launch);
      end
    end
    tick();                                   // first IDLE edge
    n_vec++;
    if (launch !== 1'b1) begin
      n_err++;
      $display("FAIL basic_relaunch: got launch=%b expected 1", launch);
    end
    start = 1'b0;
    dl_in = 64'h3;
    repeat (3) tick();
    n_vec++;
    if (valid !== 1'b1 || count !== 7'd2) begin
      n_err++;
      $display("FAIL basic_second: got valid=%b count=%0d expected 1 2", valid, count);
    end
    repeat (5) tick();                        // transfer + recovery
  endtask

  // Decode table.
  task automatic test_decode;
    logic [63:0] vec  [9];
    logic [6:0]  ecnt [9];
    logic        ebub [9];
    logic        eovf [9];
    vec  = '{64'h0000_0000_0000_00F7, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000,
             64'h0000_0000_0000_0001, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF,
             64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0005};
    ecnt = '{7'd7, 7'd64, 7'd0, 7'd1, 7'd1, 7'd63, 7'd63, 7'd32, 7'd2};
    ebub = '{1'b1, 1'b0,  1'b0, 1'b0, 1'b1, 1'b0,  1'b1,  1'b0,  1'b1};
    eovf = '{1'b0, 1'b1,  1'b0, 1'b0, 1'b0, 1'b0,  1'b0,  1'b0,  1'b0};
    ready = 1'b1;
    for (int v = 0; v < 9; v++) begin
      start = 1'b1;
      dl_in = vec[v];
      tick();                                 // E0
      start = 1'b0;
      tick();                                 // E1
      dl_in = ~vec[v];
      tick();                                 // E2
      tick();                                 // E3
      n_vec++;
      if (valid !== 1'b1 || count !== ecnt[v] || bubble !== ebub[v] || overflow !== eovf[v]) begin
        n_err++;
        $display("FAIL decode_%0d: code=%h got valid=%b count=%0d bub=%b ovf=%b expected 1 %0d %b %b",
                 v, vec[v], valid, count, bubble, overflow, ecnt[v], ebub[v], eovf[v]);
      end
      repeat (5) tick();                      // transfer + recovery
    end
  endtask

  // Stall in HOLD with start and dl_in wiggling; outputs must not move.
  task automatic test_hold_stall;
    ready = 1'b0;
    start = 1'b1;
    dl_in = 64'h0000_0000_0000_00FF;
    tick();
    start = 1'b0;
    tick();
    dl_in = '0;
    repeat (2) tick();                        // valid rises here
    for (int k = 0; k < 10; k++) begin
      start = k[0];
      dl_in = {32'hA5A5_0000 + 32'(k), 32'h0F0F_F0F0};
      tick();
      n_vec++;
      if (valid !== 1'b1 || launch !== 1'b1 || count !== 7'd8 || bubble !== 1'b0 || overflow !== 1'b0) begin
        n_err++;
        $display("FAIL stall_%0d: got valid=%b launch=%b count=%0d bub=%b ovf=%b expected 1 1 8 0 0",
                 k, valid, launch, count, bubble, overflow);
      end
    end
    start = 1'b0;
    ready = 1'b1;
    tick();
    n_vec++;
    if (valid !== 1'b0 || launch !== 1'b0 || count !== 7'd8) begin
      n_err++;
      $display("FAIL stall_xfer: got valid=%b launch=%b count=%0d expected 0 0 8",
               valid, launch, count);
    end
    // Starts seen during HOLD must not have been queued.
    for (int k = 0; k < 8; k++) begin
      tick();
      n_vec++;
      if (launch !== 1'b0 || valid !== 1'b0 || count !== 7'd8) begin
        n_err++;
        $display("FAIL stall_noqueue_%0d: got launch=%b valid=%b count=%0d expected 0 0 8",
                 k, launch, valid, count);
      end
    end
  endtask

  // Reset during CAPT aborts; a fresh start afterwards works normally.
  task automatic test_reset_mid;
    ready = 1'b1;
    start = 1'b1;
    dl_in = 64'h0000_0000_FFFF_FFFF;
    tick();                                   // E0 -> LAUNCH
    start = 1'b0;
    tick();                                   // E1 -> CAPT
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (launch !== 1'b0 || valid !== 1'b0 || count !== 7'd0) begin
      n_err++;
      $display("FAIL rstmid_immediate: got launch=%b valid=%b count=%0d expected 0 0 0",
               launch, valid, count);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_vec++;
      if (valid !== 1'b0 || launch !== 1'b0) begin
        n_err++;
        $display("FAIL rstmid_noresult_%0d: got valid=%b launch=%b expected 0 0", k, valid, launch);
      end
    end
    start = 1'b1;
    dl_in = 64'h0000_0000_0000_003F;
    tick();
    n_vec++;
    if (launch !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_relaunch: got launch=%b expected 1", launch);
    end
    start = 1'b0;
    tick();
    dl_in = '1;
    tick();
    n_vec++;
    if (valid !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_early_valid: got %b expected 0", valid);
    end
    tick();
    n_vec++;
    if (valid !== 1'b1 || count !== 7'd6 || bubble !== 1'b0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_result: got valid=%b count=%0d bub=%b ovf=%b expected 1 6 0 0",
               valid, count, bubble, overflow);
    end
    tick();
    n_vec++;
    if (valid !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_xfer: got valid=%b expected 0", valid);
    end
    repeat (4) tick();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    start = 1'b0;
    ready = 1'b0;
    dl_in = '0;
    test_reset();
    test_basic();
    test_decode();
    test_hold_stall();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tdc_therm_decoder.md
TDC_THERM_DECODER -- requirements
Module: tdc_therm_decoder

Interface
REQ-001: Parameter N, default 64, is the number of delay-line taps sampled; legal range 4..256.
REQ-002: Parameter CW, default $clog2(N+1), is the count width (7 for N=64).
REQ-003: Parameter RECOVER_CYC, default 4, is the number of cycles the launch edge is held low after each measurement; legal range 1..255.
REQ-004: clk  input  1  sole clock; all state changes on its rising edge.
REQ-005: rst_n  input  1  reset, asynchronous and active-low.
REQ-006: start  input  1  measurement request, sampled only in IDLE.
REQ-007: launch  output  1  registered edge driven into the delay-line input.
REQ-008: dl_in  input  N  thermometer code from the delay-line tap outputs, bit 0 nearest the launch point.
REQ-009: valid  output  1  result available.
REQ-010: ready  input  1  consumer accepts the result.
REQ-011: count  output  CW  number of ones in the captured code.
REQ-012: bubble  output  1  captured code is not a clean thermometer code.
REQ-013: overflow  output  1  captured code is all ones (the edge passed the entire line).

Function
REQ-014: The FSM SHALL have states IDLE, LAUNCH, CAPT, DEC, HOLD and RECOVER, and no others.
REQ-015: In IDLE with start=1 at an edge, the FSM SHALL move to LAUNCH and set launch=1; in IDLE with start=0 it SHALL stay in IDLE.
REQ-016: From LAUNCH, the next edge SHALL register dl_in into stage1 and move to CAPT.
REQ-017: From CAPT, the next edge SHALL copy stage1 into stage2 (synchronizer) and move to DEC.
REQ-018: From DEC, the next edge SHALL register count, bubble and overflow from stage2, set valid=1 and move to HOLD.
REQ-019: valid SHALL therefore rise exactly 3 edges after the edge that sampled start.
REQ-020: count SHALL equal the popcount of stage2, zero-extended to CW bits, so that a bubbled code still yields a count.
REQ-021: bubble SHALL be 1 iff some bit i of stage2 is 1 while some bit j<i is 0.
REQ-022: overflow SHALL be 1 iff all N bits of stage2 are 1, and count SHALL then equal N.
REQ-023: In HOLD, while ready=0, valid, count, bubble and overflow SHALL stay stable.
REQ-024: In HOLD, an edge with ready=1 SHALL complete the transfer: valid=0, launch=0, the recovery counter is loaded with RECOVER_CYC-1, and the FSM moves to RECOVER.
REQ-025: If ready is already high when valid rises, the transfer SHALL occur on the next edge, giving a 1-cycle valid.
REQ-026: In RECOVER, the counter SHALL decrement each edge; at 0 the FSM SHALL move to IDLE, so the line rests low for exactly RECOVER_CYC cycles.
REQ-027: launch SHALL be 1 only from LAUNCH through HOLD.
REQ-028: start outside IDLE SHALL be ignored and not queued.
REQ-029: The outputs count, bubble and overflow SHALL keep their last values after the transfer until the next DEC.
REQ-030: ready outside HOLD SHALL have no effect.

Reset
REQ-031: rst_n=0 SHALL immediately force state=IDLE, launch=0, valid=0, count=0, bubble=0, overflow=0, stage1=0, stage2=0 and recovery counter=0.
REQ-032: Reset asserted mid-measurement, in any state, SHALL abort the measurement; no valid is produced for it.
REQ-033: After rst_n deasserts, the first start SHALL be accepted at the first edge.

Verification
REQ-034: start pulse, dl_in=64'h0000_0000_0000_FFFF, ready=1 -> valid high 3 edges later for 1 cycle; count=16, bubble=0, overflow=0; launch low for 4 cycles, then IDLE.
REQ-035: dl_in=64'h0000_0000_0000_00F7 -> count=7, bubble=1, overflow=0.
REQ-036: dl_in all ones -> count=64, overflow=1, bubble=0; dl_in all zero -> count=0, overflow=0, bubble=0.
REQ-037: ready held low 10 cycles after valid, with start pulsed and dl_in changed during HOLD -> outputs stable, no new launch; transfer on the first edge with ready=1.
REQ-038: rst_n pulsed low during CAPT -> launch and valid are 0 immediately, no result is produced; a subsequent start gives a correct result with 3-edge latency.
